wb_retire_tracker: RTL and testbench

Formal/simulation companion that sits directly downstream of the RV12 write-back stage. It consumes one retirement per non-bubble WB cycle and keeps a shadow integer register file. Each retirement becomes a record carrying order number, PC, instruction, pre-state rs1/rs2 values, rd write and a control-flow continuity verdict. Records are buffered in a small FIFO behind a valid/ready interface feeding the instruction checkers.

---
 rtl/rv_retire_pkg.sv | 34 +++
 rtl/wb_retire_tracker_if.sv | 38 +++
 rtl/retire_rec_fifo.sv | 41 ++++
 rtl/wb_retire_tracker.sv | 131 +++++++++++++
 tb/tb_wb_retire_tracker.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_retire_pkg.sv
// Shared types and decode helpers for the write-back retirement tracker.
// The record layout here is what the downstream instruction checkers consume.
package rv_retire_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        SEQ  = 2'd1,
        BR   = 2'd2,
        ANY  = 2'd3
    } trk_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd;
        logic [31:0] rd_wdata;
        logic        pc_err;
    } retire_rec_t;

    function automatic logic [31:0] imm_j(input logic [31:0] insn);
        return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/wb_retire_tracker_if.sv
// Bundle between the WB stage, the retirement tracker and the record consumer.
// Record handshake: a record transfers on a clock edge where rec_valid_o and rec_ready_i are both high; while rec_valid_o is high and not accepted, all rec_* outputs hold stable.
interface wb_retire_tracker_if #(parameter int ORDER_W = 32);
    import rv_retire_pkg::*;

    logic               wb_valid_i;
    logic [31:0]        wb_pc_i;
    logic [31:0]        wb_insn_i;
    logic               wb_we_i;
    logic [4:0]         wb_rd_i;
    logic [31:0]        wb_value_i;
    logic               trap_i;
    logic               rec_valid_o;
    logic               rec_ready_i;
    logic [ORDER_W-1:0] rec_order_o;
    logic [31:0]        rec_pc_o;
    logic [31:0]        rec_insn_o;
    logic [31:0]        rec_rs1_rdata_o;
    logic [31:0]        rec_rs2_rdata_o;
    logic [4:0]         rec_rd_o;
    logic [31:0]        rec_rd_wdata_o;
    logic               rec_pc_err_o;
    logic               overflow_o;
    trk_state_t         dbg_state;

    modport master (
        output wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_rd_i, wb_value_i, trap_i, rec_ready_i,
        input  rec_valid_o, rec_order_o, rec_pc_o, rec_insn_o, rec_rs1_rdata_o, rec_rs2_rdata_o,
               rec_rd_o, rec_rd_wdata_o, rec_pc_err_o, overflow_o, dbg_state
    );

    modport slave (
        input  wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_rd_i, wb_value_i, trap_i, rec_ready_i,
        output rec_valid_o, rec_order_o, rec_pc_o, rec_insn_o, rec_rs1_rdata_o, rec_rs2_rdata_o,
               rec_rd_o, rec_rd_wdata_o, rec_pc_err_o, overflow_o, dbg_state
    );

endinterface

// File: rtl/retire_rec_fifo.sv
// Synchronous FIFO holding packed retirement records; the head reads as zero when empty.
// The caller must not push while full unless it pops in the same cycle.
module retire_rec_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_retire_tracker.sv
// Shadow register file plus PC continuity tracker behind the RV12 write-back stage.
// Each non-bubble WB cycle yields one record pushed into a small FIFO for the checkers.
module wb_retire_tracker
    import rv_retire_pkg::*;
#(
    parameter int          DEPTH   = 4,
    parameter int          ORDER_W = 32,
    parameter logic [31:0] PC_INIT = 32'h200
) (
    input logic                clk,
    input logic                rst_n,
    wb_retire_tracker_if.slave bus
);

    localparam int RW = ORDER_W + $bits(retire_rec_t);

    trk_state_t         state_q, state_d;
    logic [31:0]        exp_a_q, exp_a_d;
    logic [31:0]        exp_b_q, exp_b_d;
    logic [ORDER_W-1:0] order_q;
    logic [31:0]        regs_q [32];
    logic               overflow_q;
    logic               pc_err;
    logic               wr_en;
    logic [4:0]         rs1_idx, rs2_idx;
    logic [6:0]         opcode;
    retire_rec_t        rec_in, rec_out;
    logic [ORDER_W-1:0] order_out;
    logic [RW-1:0]      fifo_dout;
    logic               push, pop, full, empty;

    assign rs1_idx = bus.wb_insn_i[19:15];
    assign rs2_idx = bus.wb_insn_i[24:20];
    assign opcode  = bus.wb_insn_i[6:0];
    assign wr_en   = bus.wb_we_i && (bus.wb_rd_i != 5'd0);

    // Source operands come from the pre-write shadow state of this same cycle.
    always_comb begin
        rec_in           = '0;
        rec_in.pc        = bus.wb_pc_i;
        rec_in.insn      = bus.wb_insn_i;
        rec_in.rs1_rdata = (rs1_idx == 5'd0) ? 32'd0 : regs_q[rs1_idx];
        rec_in.rs2_rdata = (rs2_idx == 5'd0) ? 32'd0 : regs_q[rs2_idx];
        rec_in.rd        = wr_en ? bus.wb_rd_i : 5'd0;
        rec_in.rd_wdata  = wr_en ? bus.wb_value_i : 32'd0;
        rec_in.pc_err    = pc_err;
    end

    always_comb begin
        state_d = state_q;
        exp_a_d = exp_a_q;
        exp_b_d = exp_b_q;
        pc_err  = 1'b0;
        case (state_q)
            INIT:    pc_err = (bus.wb_pc_i != PC_INIT);
            SEQ:     pc_err = (bus.wb_pc_i != exp_a_q);
            BR:      pc_err = (bus.wb_pc_i != exp_a_q) && (bus.wb_pc_i != exp_b_q);
            default: pc_err = 1'b0;
        endcase
        if (bus.wb_valid_i) begin
            if (bus.trap_i) begin
                state_d = ANY;
            end else begin
                case (opcode)
                    OPC_JAL: begin
                        state_d = SEQ;
                        exp_a_d = bus.wb_pc_i + imm_j(bus.wb_insn_i);
                    end
                    OPC_BRANCH: begin
                        state_d = BR;
                        exp_a_d = bus.wb_pc_i + 32'd4;
                        exp_b_d = bus.wb_pc_i + imm_b(bus.wb_insn_i);
                    end
                    OPC_JALR: state_d = ANY;
                    default: begin
                        state_d = SEQ;
                        exp_a_d = bus.wb_pc_i + 32'd4;
                    end
                endcase
            end
        end
    end

    assign pop  = bus.rec_valid_o && bus.rec_ready_i;
    assign push = bus.wb_valid_i && (!full || pop);

    // A dropped record still advances order and shadow state so the gap is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            exp_a_q    <= '0;
            exp_b_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (bus.wb_valid_i) begin
            state_q <= state_d;
            exp_a_q <= exp_a_d;
            exp_b_q <= exp_b_d;
            order_q <= order_q + ORDER_W'(1);
            if (wr_en) regs_q[bus.wb_rd_i] <= bus.wb_value_i;
            if (full && !pop) overflow_q <= 1'b1;
        end
    end

    retire_rec_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({order_q, rec_in}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign {order_out, rec_out} = fifo_dout;

    assign bus.rec_valid_o     = !empty;
    assign bus.rec_order_o     = order_out;
    assign bus.rec_pc_o        = rec_out.pc;
    assign bus.rec_insn_o      = rec_out.insn;
    assign bus.rec_rs1_rdata_o = rec_out.rs1_rdata;
    assign bus.rec_rs2_rdata_o = rec_out.rs2_rdata;
    assign bus.rec_rd_o        = rec_out.rd;
    assign bus.rec_rd_wdata_o  = rec_out.rd_wdata;
    assign bus.rec_pc_err_o    = rec_out.pc_err;
    assign bus.overflow_o      = overflow_q;
    assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_wb_retire_tracker.sv
// Self-checking bench for wb_retire_tracker: a queue-based record model checked every cycle,
// plus literal expectations for the directed retirement sequences.
module tb_wb_retire_tracker;

    localparam int          DEPTH   = 4;
    localparam int          ORDER_W = 32;
    localparam logic [31:0] PC_INIT = 32'h200;
    localparam int          W       = ORDER_W + 32 * 5 + 5 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_retire_tracker_if #(.ORDER_W(ORDER_W)) bus ();

    wb_retire_tracker #(.DEPTH(DEPTH), .ORDER_W(ORDER_W), .PC_INIT(PC_INIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]       exp_q[$];
    logic [31:0]        m_regs [32];
    logic [ORDER_W-1:0] m_order;
    logic               m_ovf;
    bit                 m_any;
    logic [31:0]        m_allowed[$];
    logic [31:0]        l_order, l_rs1, l_rs2, l_rd, l_wdata, l_err;

    function automatic void check_rec(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic void check1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endfunction

    function automatic void pin(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_order   = '0;
        m_ovf     = 1'b0;
        m_any     = 1'b0;
        m_allowed = {PC_INIT};
    endfunction

    // Model: head leaves on an accepted cycle, then the new retirement is appended if room.
    always @(posedge clk) begin : model_p
        logic [31:0] pc, insn, r1, r2, wd, joff, boff;
        logic [20:0] jt;
        logic [12:0] bt;
        logic [4:0]  rdv;
        logic        err;
        if (rst_n) begin
            if (exp_q.size() != 0 && bus.rec_ready_i) void'(exp_q.pop_front());
            if (bus.wb_valid_i) begin
                pc   = bus.wb_pc_i;
                insn = bus.wb_insn_i;
                r1   = (insn[19:15] == 5'd0) ? 32'd0 : m_regs[insn[19:15]];
                r2   = (insn[24:20] == 5'd0) ? 32'd0 : m_regs[insn[24:20]];
                err  = !m_any;
                foreach (m_allowed[i]) if (m_allowed[i] == pc) err = 1'b0;
                rdv  = (bus.wb_we_i && bus.wb_rd_i != 5'd0) ? bus.wb_rd_i : 5'd0;
                wd   = (rdv != 5'd0) ? bus.wb_value_i : 32'd0;
                if (exp_q.size() < DEPTH) exp_q.push_back({m_order, pc, insn, r1, r2, rdv, wd, err});
                else m_ovf = 1'b1;
                l_order = m_order; l_rs1 = r1; l_rs2 = r2;
                l_rd = {27'd0, rdv}; l_wdata = wd; l_err = {31'd0, err};
                if (rdv != 5'd0) m_regs[rdv] = bus.wb_value_i;
                m_order = m_order + 1;
                jt   = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
                bt   = {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
                joff = {{11{jt[20]}}, jt};
                boff = {{19{bt[12]}}, bt};
                if (bus.trap_i) m_any = 1'b1;
                else if (insn[6:0] == 7'b1101111) begin m_any = 1'b0; m_allowed = {pc + joff}; end
                else if (insn[6:0] == 7'b1100011) begin m_any = 1'b0; m_allowed = {pc + 32'd4, pc + boff}; end
                else if (insn[6:0] == 7'b1100111) m_any = 1'b1;
                else begin m_any = 1'b0; m_allowed = {pc + 32'd4}; end
            end
        end
    end

    // Compare process: outputs are checked on every falling edge.
    always @(negedge clk) begin
        logic [W-1:0] act;
        act = {bus.rec_order_o, bus.rec_pc_o, bus.rec_insn_o, bus.rec_rs1_rdata_o, bus.rec_rs2_rdata_o,
               bus.rec_rd_o, bus.rec_rd_wdata_o, bus.rec_pc_err_o};
        if (!rst_n) begin
            check1("reset_valid", bus.rec_valid_o, 1'b0);
            check1("reset_overflow", bus.overflow_o, 1'b0);
            check_rec("reset_data", act, '0);
        end else begin
            check1("rec_valid", bus.rec_valid_o, exp_q.size() != 0);
            check1("overflow", bus.overflow_o, m_ovf);
            if (exp_q.size() != 0) check_rec("rec", act, exp_q[0]);
        end
    end

    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic we,
                          input logic [4:0] rd, input logic [31:0] val, input logic trap);
        bus.wb_valid_i = 1'b1;
        bus.wb_pc_i    = pc;
        bus.wb_insn_i  = insn;
        bus.wb_we_i    = we;
        bus.wb_rd_i    = rd;
        bus.wb_value_i = val;
        bus.trap_i     = trap;
        @(posedge clk);
        #1;
        bus.wb_valid_i = 1'b0;
        bus.wb_we_i    = 1'b0;
        bus.trap_i     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.wb_valid_i  = 1'b0;
        bus.wb_pc_i     = '0;
        bus.wb_insn_i   = '0;
        bus.wb_we_i     = 1'b0;
        bus.wb_rd_i     = '0;
        bus.wb_value_i  = '0;
        bus.trap_i      = 1'b0;
        bus.rec_ready_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // addi x1,x0,5 then add x2,x1,x1
        retire(32'h200, 32'h00500093, 1'b1, 5'd1, 32'd5, 1'b0);
        pin("r0_order", l_order, 32'd0);
        pin("r0_rs1", l_rs1, 32'd0);
        pin("r0_rd", l_rd, 32'd1);
        pin("r0_wdata", l_wdata, 32'd5);
        pin("r0_err", l_err, 32'd0);
        retire(32'h204, 32'h00108133, 1'b1, 5'd2, 32'd10, 1'b0);
        pin("r1_rs1", l_rs1, 32'd5);
        pin("r1_rs2", l_rs2, 32'd5);
        pin("r1_err", l_err, 32'd0);

        // jal x0,+16: hit then miss
        retire(32'h208, 32'h0100006F, 1'b0, 5'd0, 32'd0, 1'b0);
        retire(32'h218, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        pin("jal_hit_err", l_err, 32'd0);
        retire(32'h21C, 32'h0100006F, 1'b0, 5'd0, 32'd0, 1'b0);
        retire(32'h20C, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        pin("jal_miss_err", l_err, 32'd1);
        retire(32'h210, 32'h00008067, 1'b0, 5'd0, 32'd0, 1'b0);

        // beq x0,x0,-8 at 0x300, each followed by a different successor
        retire(32'h300, 32'hFE000CE3, 1'b0, 5'd0, 32'd0, 1'b0);
        pin("after_jalr_err", l_err, 32'd0);
        retire(32'h304, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        pin("br_fall_err", l_err, 32'd0);
        retire(32'h308, 32'h00008067, 1'b0, 5'd0, 32'd0, 1'b0);
        retire(32'h300, 32'hFE000CE3, 1'b0, 5'd0, 32'd0, 1'b0);
        retire(32'h2F8, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        pin("br_taken_err", l_err, 32'd0);
        retire(32'h2FC, 32'h00008067, 1'b0, 5'd0, 32'd0, 1'b0);
        retire(32'h300, 32'hFE000CE3, 1'b0, 5'd0, 32'd0, 1'b0);
        retire(32'h310, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        pin("br_miss_err", l_err, 32'd1);
        retire(32'h314, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b1);
        retire(32'h9000, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        pin("trap_err", l_err, 32'd0);

        // write to x0 is discarded, later x0 read is zero
        retire(32'h9004, 32'h00000013, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0);
        pin("x0_rd", l_rd, 32'd0);
        pin("x0_wdata", l_wdata, 32'd0);
        retire(32'h9008, 32'h000001B3, 1'b1, 5'd3, 32'd0, 1'b0);
        pin("x0_rs1", l_rs1, 32'd0);
        idle(2);

        // async reset with three records queued
        bus.rec_ready_i = 1'b0;
        retire(32'h900C, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        retire(32'h9010, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        retire(32'h9014, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        pin("queued_before_reset", exp_q.size(), 32'd3);
        rst_n = 1'b0;
        model_reset();
        #2;
        check1("reset_now_valid", bus.rec_valid_o, 1'b0);
        check1("reset_now_overflow", bus.overflow_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // five retirements into a stalled 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            retire(PC_INIT + 32'(4 * i), 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
            if (i == 0) begin
                pin("post_reset_order", l_order, 32'd0);
                pin("post_reset_err", l_err, 32'd0);
            end
        end
        check1("overflow_set", bus.overflow_o, 1'b1);
        pin("buffered_count", exp_q.size(), 32'd4);
        pin("tail_order", exp_q[3][W-1 -: 32], 32'd3);
        bus.rec_ready_i = 1'b1;
        retire(32'h214, 32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        pin("sixth_order", l_order, 32'd5);
        pin("head_after_pop", exp_q[0][W-1 -: 32], 32'd1);
        pin("new_tail_order", exp_q[3][W-1 -: 32], 32'd5);
        idle(6);
        pin("drained", exp_q.size(), 32'd0);
        check1("drained_valid", bus.rec_valid_o, 1'b0);
        check1("overflow_sticky", bus.overflow_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
